// File: rtl/ioblock_bank_if.sv
// Fabric-side bundle of the I/O bank: per-pin tristate/data controls,
// input data back to the fabric, and the serial configuration chain.
interface ioblock_bank_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] i_ts;
    logic [WIDTH-1:0] i_out;
    logic [WIDTH-1:0] o_in;
    logic             i_cfgEn;
    logic             i_cfgIn;
    logic             i_cfgLoad;
    logic             o_cfgOut;
    logic             o_cfgDone;
    logic             o_cfgErr;

    // Fabric / configuration controller side
    modport master (
        output i_ts, i_out, i_cfgEn, i_cfgIn, i_cfgLoad,
        input  o_in, o_cfgOut, o_cfgDone, o_cfgErr
    );

    // I/O bank side
    modport slave (
        input  i_ts, i_out, i_cfgEn, i_cfgIn, i_cfgLoad,
        output o_in, o_cfgOut, o_cfgDone, o_cfgErr
    );
endinterface

// File: rtl/ioblock_bank.sv
// Bank of WIDTH programmable I/O cells. A serial shadow chain holds the next
// configuration; it is copied into the active configuration only on a commit
// with a complete bit count, so the chain can be reloaded while pins run.
// Per-pin config nibble: [1:0] TSMUX, [2] DORREG (registered input),
// [3] OREG (registered output data and enable).
module ioblock_bank #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    inout  wire  [WIDTH-1:0] io_pin,
    ioblock_bank_if.slave    bus
);
    localparam int CFGW = 4;
    localparam int N    = WIDTH * CFGW;
    localparam int CW   = $clog2(N + 1);

    logic [N-1:0]     r_sh;
    logic [N-1:0]     r_act;
    logic [CW-1:0]    r_shcnt;
    logic             r_done;
    logic             r_err;
    logic [WIDTH-1:0] r_tsq;
    logic [WIDTH-1:0] r_outq;
    logic [WIDTH-1:0] r_dq;

    logic             w_full;
    logic [WIDTH-1:0] w_oeSrc;
    logic [WIDTH-1:0] w_dSrc;
    logic [WIDTH-1:0] w_drive;
    logic [WIDTH-1:0] w_in;

    // The commit decision always looks at the count before this edge's shift
    assign w_full = (r_shcnt == CW'(N));

    // Shadow chain, bit counter, commit into the active config, done/error flags
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sh    <= '0;
            r_act   <= '0;
            r_shcnt <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.i_cfgLoad) begin
                if (w_full) begin
                    r_act  <= r_sh;
                    r_err  <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_err  <= 1'b1;
                end
            end
            if (bus.i_cfgEn) begin
                r_sh <= {r_sh[N-2:0], bus.i_cfgIn};
            end
            if (bus.i_cfgLoad && w_full) begin
                r_shcnt <= bus.i_cfgEn ? CW'(1) : CW'(0);
            end else if (bus.i_cfgEn && !w_full) begin
                r_shcnt <= r_shcnt + CW'(1);
            end
        end
    end

    // Pad-side pipeline registers track every edge so switching OREG or DORREG needs no bubble
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tsq  <= '0;
            r_outq <= '0;
            r_dq   <= '0;
        end else begin
            r_tsq  <= bus.i_ts;
            r_outq <= bus.i_out;
            r_dq   <= io_pin;
        end
    end

    // Per-pin output source selection and tristate decision from the active config
    always_comb begin
        w_oeSrc = '0;
        w_dSrc  = '0;
        w_drive = '0;
        for (int k = 0; k < WIDTH; k++) begin
            w_oeSrc[k] = r_act[CFGW*k+3] ? r_tsq[k]  : bus.i_ts[k];
            w_dSrc[k]  = r_act[CFGW*k+3] ? r_outq[k] : bus.i_out[k];
            case (r_act[CFGW*k +: 2])
                2'b00:   w_drive[k] = 1'b0;
                2'b01:   w_drive[k] = w_oeSrc[k];
                2'b10:   w_drive[k] = !w_oeSrc[k];
                default: w_drive[k] = 1'b1;
            endcase
        end
    end

    // Input path: the pad value directly, or the copy captured at the last edge
    always_comb begin
        w_in = '0;
        for (int k = 0; k < WIDTH; k++) begin
            w_in[k] = r_act[CFGW*k+2] ? r_dq[k] : io_pin[k];
        end
    end

    for (genvar k = 0; k < WIDTH; k++) begin : gPad
        assign io_pin[k] = w_drive[k] ? w_dSrc[k] : 1'bz;
    end

    assign bus.o_in      = w_in;
    assign bus.o_cfgOut  = r_sh[N-1];
    assign bus.o_cfgDone = r_done;
    assign bus.o_cfgErr  = r_err;
endmodule
